// File: rtl/delay_event_scheduler_pkg.sv
// delay_event_scheduler_pkg: shared slot state encoding and sizing helper for the scheduler
package delay_event_scheduler_pkg;

  typedef enum logic [1:0] {
    FREE,
    WAIT,
    DUE
  } slot_state_e;

  // Width needed to count 0..slots occupied slots inclusive
  function automatic int pending_w(input int slots);
    return $clog2(slots + 1);
  endfunction

endpackage

// File: rtl/delay_event_scheduler_if.sv
// delay_event_scheduler_if: request/release handshake bundle between requesters, scheduler and consumer
interface delay_event_scheduler_if #(
  parameter int SLOTS = 4,
  parameter int DW    = 8,
  parameter int CW    = 8
) ();
  import delay_event_scheduler_pkg::*;

  localparam int PW = pending_w(SLOTS);

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_delay;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [PW-1:0] pending;

  modport master (
    output in_valid, in_delay, in_data, out_ready,
    input  in_ready, out_valid, out_data, pending
  );

  modport slave (
    input  in_valid, in_delay, in_data, out_ready,
    output in_ready, out_valid, out_data, pending
  );

endinterface

// File: rtl/delay_event_slot.sv
// delay_event_slot: one pending event; counts its delay down, then waits as DUE until granted
module delay_event_slot
  import delay_event_scheduler_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_delay_i,
  input  logic [DW-1:0] load_data_i,
  input  logic          release_i,
  output logic          is_free_o,
  output logic          is_due_o,
  output logic [DW-1:0] data_o
);

  slot_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;

  // Load only ever targets a FREE slot and release only a DUE one, so they never collide
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    if (load_i) begin
      state_d = (load_delay_i == '0) ? DUE : WAIT;
      cnt_d   = load_delay_i;
      data_d  = load_data_i;
    end else if (release_i) begin
      state_d = FREE;
    end else if (state_q == WAIT) begin
      cnt_d   = cnt_q - CW'(1);
      state_d = (cnt_q == CW'(1)) ? DUE : WAIT;
    end
  end

  // Slot state, countdown and payload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FREE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign is_free_o = (state_q == FREE);
  assign is_due_o  = (state_q == DUE);
  assign data_o    = data_q;

endmodule

// File: rtl/delay_event_scheduler.sv
// delay_event_scheduler: cycle-counted event delays sharing one registered output; DELAY_EVENT_SCHEDULER_ROUND_ROBIN_EN selects rotating DUE priority
module delay_event_scheduler
  import delay_event_scheduler_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int DW    = 8,
  parameter int CW    = 8
) (
  input logic                    clk,
  input logic                    rst,
  delay_event_scheduler_if.slave bus
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int PW = pending_w(SLOTS);

  logic [SLOTS-1:0] free, due, load, rel;
  logic [DW-1:0]    slot_data [SLOTS];
  logic [IW-1:0]    fsel, gsel, ptr, j;
  logic             acc, grant, out_free;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [PW-1:0]    pending_q, pending_d;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    assign load[g] = acc && (fsel == IW'(g));
    assign rel[g]  = grant && (gsel == IW'(g));
    delay_event_slot #(.DW(DW), .CW(CW)) u_slot (
      .clk          (clk),
      .rst          (rst),
      .load_i       (load[g]),
      .load_delay_i (bus.in_delay),
      .load_data_i  (bus.in_data),
      .release_i    (rel[g]),
      .is_free_o    (free[g]),
      .is_due_o     (due[g]),
      .data_o       (slot_data[g])
    );
  end

  // in_ready depends only on registered slot state, never on out_ready
  assign bus.in_ready = |free;
  assign acc          = bus.in_valid && bus.in_ready;
  assign out_free     = !out_valid_q || bus.out_ready;
  assign grant        = out_free && (|due);

  // Lowest-index FREE slot receives the next accepted event
  always_comb begin
    fsel = '0;
    for (int i = SLOTS - 1; i >= 0; i--)
      if (free[IW'(i)]) fsel = IW'(i);
  end

  // First DUE slot scanning upward from the priority pointer (wrapping)
  always_comb begin
    gsel = '0;
    j    = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % SLOTS);
      if (due[j]) gsel = j;
    end
  end

`ifdef DELAY_EVENT_SCHEDULER_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;

  assign ptr = ptr_q;

  // After a grant the slot just past the winner takes top priority
  always_comb begin
    ptr_d = grant ? ((gsel == IW'(SLOTS - 1)) ? '0 : gsel + IW'(1)) : ptr_q;
  end

  // Rotating priority pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  assign ptr = '0;
`endif

  // Output register holds under backpressure; occupancy tracks accepts minus grants
  always_comb begin
    out_valid_d = grant || (out_valid_q && !bus.out_ready);
    out_data_d  = grant ? slot_data[gsel] : out_data_q;
    pending_d   = pending_q + PW'(acc) - PW'(grant);
  end

  // Output stage and pending counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pending_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pending_q   <= pending_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_delay_event_scheduler.sv
// tb_delay_event_scheduler: randomized and directed checks against an expiry-time reference model
module tb_delay_event_scheduler;
  localparam int S  = 4;
  localparam int DW = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  delay_event_scheduler_if #(.SLOTS(S), .DW(DW), .CW(CW)) ifc ();
  delay_event_scheduler #(.SLOTS(S), .DW(DW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 0;

  // Model: each occupied slot remembers the absolute edge from which it may be released
  bit         m_occ [S];
  int         m_due [S];
  logic [7:0] m_dat [S];
  bit         m_ov;
  logic [7:0] m_od;
  int         m_ptr;
  int         ecnt = 0;

  function automatic int m_pending();
    int n = 0;
    for (int i = 0; i < S; i++) n += int'(m_occ[i]);
    return n;
  endfunction

  function automatic int m_ready();
    int r = 0;
    for (int i = 0; i < S; i++) if (!m_occ[i]) r = 1;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int g = -1;
    int f = -1;
    bit fo;
    fo = !m_ov || ifc.out_ready;
    if (fo)
      for (int k = 0; k < S; k++) begin
        int idx = (m_ptr + k) % S;
        if (g < 0 && m_occ[idx] && ecnt >= m_due[idx]) g = idx;
      end
    for (int k = S - 1; k >= 0; k--) if (!m_occ[k]) f = k;
    if (g >= 0) begin
      m_od = m_dat[g];
      m_ov = 1;
      m_occ[g] = 0;
`ifdef DELAY_EVENT_SCHEDULER_ROUND_ROBIN_EN
      m_ptr = (g + 1) % S;
`endif
    end else if (fo) begin
      m_ov = 0;
    end
    if (ifc.in_valid && f >= 0) begin
      m_occ[f] = 1;
      m_due[f] = ecnt + int'(ifc.in_delay) + 1;
      m_dat[f] = ifc.in_data;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    ecnt++;
    if (rst) begin
      for (int i = 0; i < S; i++) m_occ[i] = 0;
      m_ov  = 0;
      m_od  = '0;
      m_ptr = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("in_ready", int'(ifc.in_ready), m_ready());
      chk("out_valid", int'(ifc.out_valid), int'(m_ov));
      chk("out_data", int'(ifc.out_data), int'(m_od));
      chk("pending", int'(ifc.pending), m_pending());
    end
  end

  task automatic drive(input bit v, input int d, input int dat);
    ifc.in_valid = v;
    ifc.in_delay = d[CW-1:0];
    ifc.in_data  = dat[DW-1:0];
  endtask

  task automatic wait_ov(input string name, input int bound);
    int k = 0;
    while (!ifc.out_valid && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(name, int'(ifc.out_valid), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int got5 [3];
    int exp5 [3];
    exp5 = '{'h11, 'h22, 'h33};
    ifc.out_ready = 1;
    drive(0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    chk_on = 1;
    chk("rst_out_valid", int'(ifc.out_valid), 0);
    chk("rst_out_data", int'(ifc.out_data), 0);
    chk("rst_pending", int'(ifc.pending), 0);
    chk("rst_in_ready", int'(ifc.in_ready), 1);

    drive(1, 5, 'hA5);
    @(negedge clk);
    drive(0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      chk("t1_out_valid", int'(ifc.out_valid), int'(k == 6));
      chk("t1_pending", int'(ifc.pending), int'(k < 6));
      if (k == 6) chk("t1_out_data", int'(ifc.out_data), 'hA5);
      @(negedge clk);
    end

    for (int k = 0; k < 8; k++) begin
      if (k >= 2) begin
        chk("t2_out_valid", int'(ifc.out_valid), 1);
        chk("t2_out_data", int'(ifc.out_data), 'h3C + k - 2);
      end
      chk("t2_in_ready", int'(ifc.in_ready), 1);
      drive(1, 0, 'h3C + k);
      @(negedge clk);
    end
    drive(0, 0, 0);
    repeat (4) @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      drive(1, 20, 'h40 + k);
      @(negedge clk);
    end
    chk("t3_in_ready_full", int'(ifc.in_ready), 0);
    chk("t3_pending_full", int'(ifc.pending), 4);
    drive(1, 20, 'h55);
    cnt = 0;
    while (!ifc.in_ready && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("t3_full_cycles", cnt, 18);
    @(negedge clk);
    drive(0, 0, 0);
    repeat (40) @(negedge clk);

    ifc.out_ready = 0;
    drive(1, 2, 'hA1);
    @(negedge clk);
    drive(1, 2, 'hA2);
    @(negedge clk);
    drive(0, 0, 0);
    wait_ov("t4_wait_valid", 10);
    repeat (10) begin
      chk("t4_hold_valid", int'(ifc.out_valid), 1);
      chk("t4_hold_data", int'(ifc.out_data), 'hA1);
      chk("t4_hold_pending", int'(ifc.pending), 1);
      @(negedge clk);
    end
    ifc.out_ready = 1;
    @(negedge clk);
    chk("t4_second_valid", int'(ifc.out_valid), 1);
    chk("t4_second_data", int'(ifc.out_data), 'hA2);
    @(negedge clk);
    chk("t4_drained", int'(ifc.out_valid), 0);
    repeat (3) @(negedge clk);

    drive(1, 4, 'h11);
    @(negedge clk);
    drive(1, 3, 'h22);
    @(negedge clk);
    drive(1, 2, 'h33);
    @(negedge clk);
    drive(0, 0, 0);
    wait_ov("t5_wait_valid", 10);
    for (int k = 0; k < 3; k++) begin
      chk("t5_valid", int'(ifc.out_valid), 1);
      got5[k] = int'(ifc.out_data);
      @(negedge clk);
    end
`ifndef DELAY_EVENT_SCHEDULER_ROUND_ROBIN_EN
    for (int k = 0; k < 3; k++) chk("t5_order", got5[k], exp5[k]);
`endif
    repeat (3) @(negedge clk);

    drive(1, 255, 'h7E);
    @(negedge clk);
    drive(0, 0, 0);
    cnt = 0;
    while (!ifc.out_valid && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    chk("tmax_latency", cnt, 256);
    chk("tmax_data", int'(ifc.out_data), 'h7E);
    repeat (3) @(negedge clk);

    ifc.out_ready = 0;
    drive(1, 0, 'hE1);
    @(negedge clk);
    drive(1, 10, 'hE2);
    @(negedge clk);
    drive(1, 10, 'hE3);
    @(negedge clk);
    drive(1, 10, 'hE4);
    @(negedge clk);
    drive(0, 0, 0);
    chk("t6_pre_valid", int'(ifc.out_valid), 1);
    chk("t6_pre_pending", int'(ifc.pending), 3);
    #2 rst = 1;
    #1;
    chk("t6_rst_valid", int'(ifc.out_valid), 0);
    chk("t6_rst_pending", int'(ifc.pending), 0);
    #1 rst = 0;
    ifc.out_ready = 1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (ifc.out_valid) cnt++;
    end
    chk("t6_no_emit", cnt, 0);

    repeat (3000) begin
      int r;
      r = int'($urandom_range(0, 99));
      drive($urandom_range(0, 1) == 1,
            (r < 3) ? 255 : (r < 20) ? 0 : int'($urandom_range(1, 12)),
            int'($urandom_range(0, 255)));
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    drive(0, 0, 0);
    ifc.out_ready = 1;
    repeat (300) @(negedge clk);
    chk("final_pending", int'(ifc.pending), 0);
    chk("final_valid", int'(ifc.out_valid), 0);

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/delay_event_scheduler.md
Name: delay_event_scheduler

Overview:
- Synthesizable, cycle-counted replacement for procedural `#N` delays.
- Requesters post timed events (payload + delay in clock cycles). The block holds up to SLOTS pending events and counts each one down.
- Expired events are released through a single registered valid/ready output port.
- Sits between timing-intent logic (delay-annotated assignments) and the consuming datapath. It schedules and shares one output resource across all in-flight events.

Parameters:
- SLOTS, 4, number of concurrently pending events (≥2).
- DW, 8, payload width in bits.
- CW, 8, delay counter width; maximum delay is 2^CW-1 cycles.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  event offered.
- in_ready  output  1  a free slot exists; handshake completes when in_valid && in_ready at a clk edge.
- in_delay  input  CW  delay in cycles.
- in_data  input  DW  payload.
- out_valid  output  1  registered; expired event present.
- out_ready  input  1  consumer accepts.
- out_data  output  DW  registered payload; stable while out_valid && !out_ready.
- pending  output  $clog2(SLOTS+1)  number of occupied slots, excluding the output register.

Behaviour:
- Reset (async assert, sync-safe deassert): all slots FREE, cnt=0; out_valid=0, out_data=0, pending=0. in_ready=1 once rst is low. Reset mid-operation discards all events, including one held in the output register.
- Slot state per slot: FREE, WAIT, DUE.
- Accept: load the lowest-index FREE slot with cnt=in_delay and data=in_data.
  - State becomes DUE if in_delay==0, else WAIT.
- WAIT: cnt decrements by 1 every cycle. When cnt==1, the next state is DUE (cnt reaches 0).
- Output stage is "free" when !out_valid, or out_valid && out_ready in the same cycle.
  - When free and any slot is DUE, select one DUE slot (fixed priority: lowest index).
  - Load its data into out_data, set out_valid=1, free the slot at that edge.
- Output stage not free: DUE slots hold; no counting in DUE. Backpressure never drops events.
- No DUE slots and the output is drained: out_valid=0 and out_data holds its last value.
- Latency:
  - Event accepted at edge t with delay D and an unblocked output: out_valid high after edge t+D+1.
  - D=0 gives one cycle.
  - D=2^CW-1 counts without wrap.
- in_ready is computed from registered slot state only, so it is not combinationally dependent on out_ready.
  - A slot freed at edge t is accepting from edge t+1.
- Full (pending==SLOTS): in_ready=0 and in_valid is ignored.
- Simultaneous accept and release in one cycle: both occur. pending is unchanged.
- Events sharing an expiry cycle are ordered by selection priority, not by arrival.
- Payload is never modified; in_delay is captured only at the handshake.

Optional Feature:
DELAY_EVENT_SCHEDULER_ROUND_ROBIN_EN
- Defined: DUE-slot selection uses a rotating priority pointer. After granting slot k, the pointer becomes (k+1) mod SLOTS, so the highest priority starts at slot k+1. The pointer resets to 0.
- Undefined: fixed lowest-index priority as above.
- Free-slot allocation is lowest-index in both builds.

Decomposition:
- Package delay_event_scheduler_pkg: enum slot_state_e {FREE, WAIT, DUE} and a helper function for the pending width.
- Sub-module delay_event_slot: one slot. Holds state, cnt and data.
  - Inputs: load, load_delay, load_data, release.
  - Outputs: is_free, is_due, data.
- Top instantiates SLOTS slots via generate. Top contains the free-slot encoder, the DUE arbiter, the output register and the pending counter.

Test Plan:
1. Single event: accept {delay=5, data=8'hA5} at edge 10 with out_ready=1 → out_valid rises after edge 16, out_data=8'hA5 for exactly one cycle. pending=1 during cycles 11–16, then 0.
2. Zero delay: delay=0, data=8'h3C → out_valid one cycle after accept. Back-to-back zero-delay events every cycle sustain throughput of 1/cycle with no in_ready drop.
3. Fill/full: 4 events with delay=20 on consecutive cycles → in_ready=0 and pending=4; a 5th in_valid is not accepted. After the first release, in_ready returns the following cycle.
4. Backpressure: event delay=2, out_ready=0 for 10 cycles → out_valid stays high with out_data stable; the next DUE event waits. No loss, correct order after out_ready=1.
5. Collision: slots 0, 1, 2 expire in the same cycle (data 8'h11, 8'h22, 8'h33) → released 11, 22, 33 on consecutive cycles. Round-robin build with pointer at 2 releases 33, 11, 22.
6. Reset mid-operation: 3 pending events plus out_valid=1, assert rst asynchronously between edges → out_valid=0 and pending=0 immediately; nothing is emitted after deassert.
